// File: rtl/imem_responder.sv
// -----------------------------------------------------------------------------
// imem_responder
// Instruction-memory responder for the fetch stage. A request is accepted on
// valid/ready. The word is read from a word-addressed array in the accept
// cycle, carried down a fixed-latency pipeline, and pushed into an in-order
// response queue. An outstanding-credit counter (pipeline + queue entries)
// guarantees queue space on arrival, so the pipeline never stalls. flush_i
// drops everything in flight. A loader port writes the array at any time.
//
// Ports
//   clk_i, rst_n_i            clock, async active-low reset
//   req_valid_i/req_ready_o   fetch request handshake, req_addr_i = byte address
//   rsp_valid_o/rsp_ready_i   response handshake (queue head)
//   rsp_instr_o/addr_o/err_o  response payload; held at last popped when empty
//   flush_i                   discard all in-flight and queued responses
//   ld_we_i/ld_addr_i/ld_data_i  loader write port (word index)
// -----------------------------------------------------------------------------
module imem_responder #(
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 32,
    parameter int MEM_WORDS   = 4096,
    parameter int LAT         = 2,
    parameter int FIFO_DEPTH  = 4,
    localparam int AW         = $clog2(MEM_WORDS)
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [PC_WIDTH-1:0]    req_addr_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [INSTR_WIDTH-1:0] rsp_instr_o,
    output logic [PC_WIDTH-1:0]    rsp_addr_o,
    output logic                   rsp_err_o,
    input  logic                   flush_i,
    input  logic                   ld_we_i,
    input  logic [AW-1:0]          ld_addr_i,
    input  logic [INSTR_WIDTH-1:0] ld_data_i
);

    localparam int EW = INSTR_WIDTH + PC_WIDTH + 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int QW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CW-1:0]          CREDIT_MAX = CW'(FIFO_DEPTH);
    localparam logic [QW-1:0]          Q_LAST     = QW'(FIFO_DEPTH - 1);
    localparam logic [INSTR_WIDTH-1:0] NOP_INSTR  = INSTR_WIDTH'(32'h0000_0013);

    logic [INSTR_WIDTH-1:0] r_mem [MEM_WORDS];

    logic [EW-1:0] r_q_mem [2**QW];
    logic [QW-1:0] r_q_head;
    logic [QW-1:0] r_q_tail;
    logic [CW-1:0] r_q_cnt;
    logic [CW-1:0] r_credit;
    logic [EW-1:0] r_last;

    logic [AW-1:0] w_idx;
    logic          w_misalign;
    logic          w_oor;
    logic          w_err;
    logic          w_acc;
    logic [EW-1:0] w_acc_data;
    logic          w_push_valid;
    logic [EW-1:0] w_push_data;
    logic          w_push;
    logic          w_pop;
    logic          w_q_empty;
    logic [EW-1:0] w_head;

    function automatic logic [QW-1:0] f_next(input logic [QW-1:0] p);
        return (p == Q_LAST) ? '0 : p + 1'b1;
    endfunction

    // Ready depends only on registered credit, flush and reset.
    assign req_ready_o = rst_n_i && !flush_i && (r_credit < CREDIT_MAX);
    assign w_acc       = req_valid_i && req_ready_o;

    assign w_idx      = req_addr_i[AW+1:2];
    assign w_misalign = |req_addr_i[1:0];
    assign w_oor      = (req_addr_i[PC_WIDTH-1:2] >> AW) != '0;
    assign w_err      = w_misalign || w_oor;
    // Combinational read in the accept cycle gives read-first behaviour
    // against a same-cycle loader write.
    assign w_acc_data = {w_err, req_addr_i, (w_err ? NOP_INSTR : r_mem[w_idx])};

    always_ff @(posedge clk_i) begin
        if (ld_we_i) begin
            r_mem[ld_addr_i] <= ld_data_i;
        end
    end

    // LAT-1 registered stages; with LAT==1 the accept feeds the queue directly.
    if (LAT == 1) begin : g_no_pipe
        assign w_push_valid = w_acc;
        assign w_push_data  = w_acc_data;
    end else begin : g_pipe
        logic [LAT-2:0] r_pv;
        logic [EW-1:0]  r_pd [LAT-1];

        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                r_pv <= '0;
            end else if (flush_i) begin
                r_pv <= '0;
            end else begin
                r_pv[0] <= w_acc;
                for (int i = 1; i < LAT - 1; i++) begin
                    r_pv[i] <= r_pv[i-1];
                end
            end
        end

        always_ff @(posedge clk_i) begin
            r_pd[0] <= w_acc_data;
            for (int i = 1; i < LAT - 1; i++) begin
                r_pd[i] <= r_pd[i-1];
            end
        end

        assign w_push_valid = r_pv[LAT-2];
        assign w_push_data  = r_pd[LAT-2];
    end

    assign w_q_empty   = (r_q_cnt == '0);
    assign w_head      = r_q_mem[r_q_head];
    assign rsp_valid_o = !w_q_empty;
    assign w_push      = w_push_valid && !flush_i;
    assign w_pop       = rsp_valid_o && rsp_ready_i && !flush_i;

    // An empty queue presents the last popped entry so outputs never glitch.
    assign {rsp_err_o, rsp_addr_o, rsp_instr_o} = w_q_empty ? r_last : w_head;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_q_head <= '0;
            r_q_tail <= '0;
            r_q_cnt  <= '0;
            r_credit <= '0;
            r_last   <= '0;
        end else if (flush_i) begin
            r_q_head <= '0;
            r_q_tail <= '0;
            r_q_cnt  <= '0;
            r_credit <= '0;
        end else begin
            if (w_push) begin
                r_q_tail <= f_next(r_q_tail);
            end
            if (w_pop) begin
                r_q_head <= f_next(r_q_head);
                r_last   <= w_head;
            end
            case ({w_push, w_pop})
                2'b10:   r_q_cnt <= r_q_cnt + 1'b1;
                2'b01:   r_q_cnt <= r_q_cnt - 1'b1;
                default: r_q_cnt <= r_q_cnt;
            endcase
            case ({w_acc, w_pop})
                2'b10:   r_credit <= r_credit + 1'b1;
                2'b01:   r_credit <= r_credit - 1'b1;
                default: r_credit <= r_credit;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_q_mem[r_q_tail] <= w_push_data;
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// -----------------------------------------------------------------------------
// tb_imem_responder
// Table-driven requests plus hand-written corner sequences. Each accepted
// request pushes its expected response (with accept cycle) to a scoreboard;
// every cycle the bench predicts req_ready_o, rsp_valid_o and the payload
// and compares against the DUT at the falling edge.
// -----------------------------------------------------------------------------
module tb_imem_responder;

    localparam int LAT = 2;
    localparam int FD  = 4;
    localparam int MW  = 4096;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic [31:0] rsp_addr;
    logic        rsp_err;
    logic        flush;
    logic        ld_we;
    logic [11:0] ld_addr;
    logic [31:0] ld_data;

    imem_responder #(
        .PC_WIDTH(32), .INSTR_WIDTH(32), .MEM_WORDS(MW), .LAT(LAT), .FIFO_DEPTH(FD)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_instr_o(rsp_instr), .rsp_addr_o(rsp_addr), .rsp_err_o(rsp_err),
        .flush_i(flush),
        .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_data_i(ld_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        err;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        err;
        int          t;
    } sb_t;

    vec_t        tbl [10];
    logic [31:0] init_words [4];
    sb_t         sb [$];
    sb_t         head;
    logic [31:0] last_instr;
    logic [31:0] last_addr;
    logic        last_err;
    logic [31:0] nx_instr;
    logic        nx_err;
    bit          acc_seen;
    bit          dut_acc;
    int          n_vec  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    int          n_acc;
    int          k;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got %h, want %h", name, cyc, act, exp);
        end
    endtask

    // One clock: predict and compare at the falling edge, update the
    // scoreboard from the handshakes of this cycle, then return #1 after the
    // next rising edge so the caller can drive the following cycle.
    task automatic cycle();
        bit exp_ready;
        bit exp_valid;
        @(negedge clk);
        if (!rst_n) begin
            sb.delete();
            last_instr = '0;
            last_addr  = '0;
            last_err   = 1'b0;
        end
        exp_ready = rst_n && !flush && (sb.size() < FD);
        exp_valid = 1'b0;
        if (rst_n && sb.size() > 0) begin
            head = sb[0];
            exp_valid = (head.t + LAT <= cyc);
        end
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
        if (exp_valid) begin
            chk("rsp_instr", rsp_instr, head.instr);
            chk("rsp_addr",  rsp_addr,  head.addr);
            chk("rsp_err",   32'(rsp_err), 32'(head.err));
        end else begin
            chk("idle_instr", rsp_instr, last_instr);
            chk("idle_addr",  rsp_addr,  last_addr);
            chk("idle_err",   32'(rsp_err), 32'(last_err));
        end
        acc_seen = 1'b0;
        dut_acc  = req_valid && req_ready;
        if (rst_n) begin
            if (flush) begin
                sb.delete();
            end else begin
                if (exp_valid && rsp_ready) begin
                    last_instr = head.instr;
                    last_addr  = head.addr;
                    last_err   = head.err;
                    void'(sb.pop_front());
                end
                if (req_valid && exp_ready) begin
                    sb.push_back('{instr: nx_instr, addr: req_addr, err: nx_err, t: cyc});
                    acc_seen = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive_req(input int idx);
        req_valid = 1'b1;
        req_addr  = tbl[idx].addr;
        nx_instr  = tbl[idx].instr;
        nx_err    = tbl[idx].err;
    endtask

    initial begin
        init_words[0] = 32'h0010_0093;
        init_words[1] = 32'h0020_0113;
        init_words[2] = 32'h0030_0193;
        init_words[3] = 32'h0040_0213;
        tbl[0] = '{addr: 32'h0000_0000, instr: 32'h0010_0093, err: 1'b0};
        tbl[1] = '{addr: 32'h0000_0004, instr: 32'h0020_0113, err: 1'b0};
        tbl[2] = '{addr: 32'h0000_0008, instr: 32'h0030_0193, err: 1'b0};
        tbl[3] = '{addr: 32'h0000_000C, instr: 32'h0040_0213, err: 1'b0};
        tbl[4] = '{addr: 32'h0000_0002, instr: 32'h0000_0013, err: 1'b1};
        tbl[5] = '{addr: 32'h0000_4000, instr: 32'h0000_0013, err: 1'b1};
        tbl[6] = '{addr: 32'h0000_0004, instr: 32'h0020_0113, err: 1'b0};
        tbl[7] = '{addr: 32'hFFFF_FFFC, instr: 32'h0000_0013, err: 1'b1};
        tbl[8] = '{addr: 32'h0000_0007, instr: 32'h0000_0013, err: 1'b1};
        tbl[9] = '{addr: 32'h0000_000C, instr: 32'h0040_0213, err: 1'b0};

        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
        flush = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_data = '0;
        nx_instr = '0; nx_err = 1'b0;
        last_instr = '0; last_addr = '0; last_err = 1'b0;

        // Reset state, then loader fill
        repeat (2) cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ld_we = 1'b1; ld_addr = 12'(i); ld_data = init_words[i];
            cycle();
        end
        ld_we = 1'b0;
        cycle();

        // Back-to-back table requests, consumer always ready
        rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive_req(i);
            cycle();
        end
        req_valid = 1'b0;
        repeat (4) cycle();

        // Backpressure: only FD requests fit, head holds stable
        rsp_ready = 1'b0;
        k = 0; n_acc = 0;
        for (int c = 0; c < 8; c++) begin
            drive_req(k % 4);
            cycle();
            if (dut_acc) n_acc++;
            if (acc_seen) k++;
        end
        chk("stall_accepts", 32'(n_acc), 32'd4);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (7) cycle();

        // Flush with three outstanding and a request pending in the flush cycle
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_req(i);
            cycle();
        end
        flush = 1'b1; drive_req(0); rsp_ready = 1'b1;
        cycle();
        chk("flush_no_accept", 32'(dut_acc), 32'd0);
        flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        repeat (4) cycle();
        rsp_ready = 1'b1;
        drive_req(2);
        cycle();
        req_valid = 1'b0;
        repeat (4) cycle();

        // Same-cycle loader write to the word being read returns old data
        req_valid = 1'b1; req_addr = 32'h4; nx_instr = 32'h0020_0113; nx_err = 1'b0;
        ld_we = 1'b1; ld_addr = 12'd1; ld_data = 32'hDEAD_BEEF;
        cycle();
        ld_we = 1'b0;
        nx_instr = 32'hDEAD_BEEF;
        cycle();
        req_valid = 1'b0;
        repeat (4) cycle();

        // Reset mid-stream with two in flight
        drive_req(0);
        cycle();
        drive_req(3);
        cycle();
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_instr", rsp_instr, 32'd0);
        chk("rst_addr",  rsp_addr,  32'd0);
        chk("rst_err",   32'(rsp_err), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        repeat (2) cycle();
        rst_n = 1'b1;
        repeat (5) cycle();
        drive_req(1);
        nx_instr = 32'hDEAD_BEEF;
        cycle();
        req_valid = 1'b0;
        repeat (4) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
